// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolution controller for the ID stage of the RV32I pipeline.
// It sequences the shared comparator, stalls ID until the operands are ready,
// and raises a one-cycle redirect/flush (or misaligned-target) pulse for taken
// control transfers. Static predict-not-taken. Also keeps branch/taken counters.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no control transfer in flight; accept a new one from ID
//   S_WAIT | control transfer in ID, operands not ready yet (stall)
//   S_CMP  | operands captured; comparator active, outcome resolved
module branch_resolve_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic             id_is_branch,
    input  logic             id_is_jal,
    input  logic             id_is_jalr,
    input  logic [2:0]       id_funct3,
    input  logic [31:0]      id_pc,
    input  logic [31:0]      id_imm,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic             rs1_ready,
    input  logic             rs2_ready,
    input  logic             flush_in,
    output logic [31:0]      cmp_a,
    output logic [31:0]      cmp_b,
    output logic [2:0]       cmp_ctrl,
    input  logic             cmp_c,
    output logic             stall_id,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush_fetch,
    output logic             exc_misalign,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CMP  = 2'd2
    } state_t;

    state_t           state_q, state_d;

    logic             op_br_q, op_jal_q, op_jalr_q;
    logic [2:0]       f3_q;
    logic [31:0]      pc_q, imm_q, rs1_q, rs2_q;

    logic             rv_q, rv_d;
    logic             exc_q, exc_d;
    logic [31:0]      rpc_q, rpc_d;
    logic [CNT_W-1:0] br_q, br_d;
    logic [CNT_W-1:0] tk_q, tk_d;

    logic             is_ctl;
    logic             need_ok;
    logic             capture;
    logic             stall;
    logic [2:0]       ctrl_dec;
    logic             taken;
    logic [31:0]      target;

    // Map branch funct3 onto the comparator opcode; reserved encodings give "none".
    function automatic logic [2:0] f3_to_ctrl(input logic [2:0] f3);
        case (f3)
            3'b000:  return 3'b001;   // BEQ
            3'b001:  return 3'b010;   // BNE
            3'b100:  return 3'b011;   // BLT
            3'b101:  return 3'b101;   // BGE
            3'b110:  return 3'b100;   // BLTU
            3'b111:  return 3'b110;   // BGEU
            default: return 3'b000;
        endcase
    endfunction

    // Qualify the ID instruction and check operand readiness for its type.
    always_comb begin
        is_ctl  = id_valid & (id_is_branch | id_is_jal | id_is_jalr) & ~rv_q & ~flush_in;
        need_ok = (~id_is_branch | (rs1_ready & rs2_ready)) & (~id_is_jalr | rs1_ready);
    end

    // Resolve the captured operation: comparator op, taken decision and target.
    always_comb begin
        ctrl_dec = op_br_q ? f3_to_ctrl(f3_q) : 3'b000;
        // A "none" comparator op must never take a branch, whatever cmp_c says.
        taken    = op_jal_q | op_jalr_q | (op_br_q & cmp_c & (ctrl_dec != 3'b000));
        target   = op_jalr_q ? ((rs1_q + imm_q) & 32'hFFFF_FFFE) : (pc_q + imm_q);
    end

    // Next-state, stall, comparator control and registered-output updates.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        stall    = 1'b0;
        cmp_ctrl = 3'b000;
        rv_d     = 1'b0;
        exc_d    = 1'b0;
        rpc_d    = rpc_q;
        br_d     = br_q;
        tk_d     = tk_q;
        case (state_q)
            S_IDLE: begin
                if (is_ctl) begin
                    stall = 1'b1;
                    if (need_ok) begin
                        capture = 1'b1;
                        state_d = S_CMP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (flush_in) begin
                    state_d = S_IDLE;
                end else begin
                    stall = 1'b1;
                    if (need_ok) begin
                        capture = 1'b1;
                        state_d = S_CMP;
                    end
                end
            end
            S_CMP: begin
                cmp_ctrl = ctrl_dec;
                state_d  = S_IDLE;
                // A trap flush kills the op: no pulse, no statistics.
                if (!flush_in) begin
                    br_d = br_q + CNT_W'(1);
                    if (taken) begin
                        tk_d = tk_q + CNT_W'(1);
                        if (target[1]) begin
                            exc_d = 1'b1;
                        end else begin
                            rv_d  = 1'b1;
                            rpc_d = target;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, pulse outputs, redirect target and statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rv_q    <= 1'b0;
            exc_q   <= 1'b0;
            rpc_q   <= 32'h0;
            br_q    <= '0;
            tk_q    <= '0;
        end else begin
            state_q <= state_d;
            rv_q    <= rv_d;
            exc_q   <= exc_d;
            rpc_q   <= rpc_d;
            br_q    <= br_d;
            tk_q    <= tk_d;
        end
    end

    // Operand capture; rs*_data is sampled only on the capture cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_br_q   <= 1'b0;
            op_jal_q  <= 1'b0;
            op_jalr_q <= 1'b0;
            f3_q      <= 3'b000;
            pc_q      <= 32'h0;
            imm_q     <= 32'h0;
            rs1_q     <= 32'h0;
            rs2_q     <= 32'h0;
        end else if (capture) begin
            op_br_q   <= id_is_branch;
            op_jal_q  <= id_is_jal;
            op_jalr_q <= id_is_jalr;
            f3_q      <= id_funct3;
            pc_q      <= id_pc;
            imm_q     <= id_imm;
            rs1_q     <= rs1_data;
            rs2_q     <= rs2_data;
        end
    end

    // Stall is combinational from state; hold it low while reset is asserted.
    assign stall_id       = stall & rst_n;
    assign cmp_a          = rs1_q;
    assign cmp_b          = rs2_q;
    assign redirect_valid = rv_q;
    assign flush_fetch    = rv_q;
    assign redirect_pc    = rpc_q;
    assign exc_misalign   = exc_q;
    assign br_cnt         = br_q;
    assign taken_cnt      = tk_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a transaction-level outcome model.
module tb_branch_resolve_ctrl;

    localparam int K_BR   = 0;
    localparam int K_JAL  = 1;
    localparam int K_JALR = 2;

    logic        clk, rst_n;
    logic        id_valid, id_is_branch, id_is_jal, id_is_jalr;
    logic [2:0]  id_funct3;
    logic [31:0] id_pc, id_imm, rs1_data, rs2_data;
    logic        rs1_ready, rs2_ready, flush_in;
    logic [31:0] cmp_a, cmp_b;
    logic [2:0]  cmp_ctrl;
    logic        cmp_c;
    logic        stall_id, redirect_valid, flush_fetch, exc_misalign;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt, taken_cnt;

    logic [31:0] cmp_a4, cmp_b4, redirect_pc4;
    logic [2:0]  cmp_ctrl4;
    logic        cmp_c4, stall_id4, redirect_valid4, flush_fetch4, exc_misalign4;
    logic [3:0]  br_cnt4, taken_cnt4;

    int n_err = 0;
    int n_chk = 0;

    // model expectations for the current cycle
    logic        chk_en = 1'b0;
    logic        exp_stall = 1'b0, exp_rv = 1'b0, exp_exc = 1'b0, in_cmp = 1'b0;
    logic [2:0]  exp_ctrl = 3'b000;
    logic [31:0] exp_rpc = 32'h0, exp_a = 32'h0, exp_b = 32'h0;
    logic [31:0] exp_br = 32'h0, exp_tk = 32'h0;
    // registered effects produced by the cycle in progress
    logic        nxt_rv = 1'b0, nxt_exc = 1'b0, nxt_br = 1'b0, nxt_tk = 1'b0;
    logic [31:0] nxt_pc = 32'h0;

    branch_resolve_ctrl #(.CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr), .id_funct3(id_funct3),
        .id_pc(id_pc), .id_imm(id_imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_ready(rs1_ready), .rs2_ready(rs2_ready), .flush_in(flush_in),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_ctrl(cmp_ctrl), .cmp_c(cmp_c),
        .stall_id(stall_id), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_fetch(flush_fetch), .exc_misalign(exc_misalign),
        .br_cnt(br_cnt), .taken_cnt(taken_cnt)
    );

    branch_resolve_ctrl #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_is_branch(id_is_branch),
        .id_is_jal(id_is_jal), .id_is_jalr(id_is_jalr), .id_funct3(id_funct3),
        .id_pc(id_pc), .id_imm(id_imm), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .rs1_ready(rs1_ready), .rs2_ready(rs2_ready), .flush_in(flush_in),
        .cmp_a(cmp_a4), .cmp_b(cmp_b4), .cmp_ctrl(cmp_ctrl4), .cmp_c(cmp_c4),
        .stall_id(stall_id4), .redirect_valid(redirect_valid4), .redirect_pc(redirect_pc4),
        .flush_fetch(flush_fetch4), .exc_misalign(exc_misalign4),
        .br_cnt(br_cnt4), .taken_cnt(taken_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // the shared comparator the controller drives
    function automatic logic cmp_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'b001:  return a == b;
            3'b010:  return a != b;
            3'b011:  return $signed(a) < $signed(b);
            3'b100:  return a < b;
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction
    assign cmp_c  = cmp_fn(cmp_ctrl, cmp_a, cmp_b);
    assign cmp_c4 = cmp_fn(cmp_ctrl4, cmp_a4, cmp_b4);

    // RV32I branch semantics straight from funct3
    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] exp_code(input logic [2:0] f3);
        case (f3)
            3'b000:  return 3'b001;
            3'b001:  return 3'b010;
            3'b100:  return 3'b011;
            3'b101:  return 3'b101;
            3'b110:  return 3'b100;
            3'b111:  return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("stall_id", {31'd0, stall_id}, {31'd0, exp_stall});
                chk("cmp_ctrl", {29'd0, cmp_ctrl}, {29'd0, exp_ctrl});
                chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_rv});
                chk("flush_fetch", {31'd0, flush_fetch}, {31'd0, exp_rv});
                chk("exc_misalign", {31'd0, exc_misalign}, {31'd0, exp_exc});
                chk("br_cnt", br_cnt, exp_br);
                chk("taken_cnt", taken_cnt, exp_tk);
                chk("br_cnt4", {28'd0, br_cnt4}, exp_br & 32'hF);
                chk("taken_cnt4", {28'd0, taken_cnt4}, exp_tk & 32'hF);
                if (exp_rv) chk("redirect_pc", redirect_pc, exp_rpc);
                if (in_cmp) begin
                    chk("cmp_a", cmp_a, exp_a);
                    chk("cmp_b", cmp_b, exp_b);
                end
            end
        end
    end

    // advance one cycle and apply the registered effects of the previous one
    task automatic tick();
        @(posedge clk);
        #1;
        exp_rv  = nxt_rv;
        exp_exc = nxt_exc;
        if (nxt_rv) exp_rpc = nxt_pc;
        exp_br  = exp_br + {31'd0, nxt_br};
        exp_tk  = exp_tk + {31'd0, nxt_tk};
        nxt_rv  = 1'b0;
        nxt_exc = 1'b0;
        nxt_br  = 1'b0;
        nxt_tk  = 1'b0;
        exp_stall = 1'b0;
        exp_ctrl  = 3'b000;
        in_cmp    = 1'b0;
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // present one control transfer in ID and follow it until it resolves
    task automatic do_op(input int kind, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] r2,
                         input int nrdy, input logic fl);
        logic        tk;
        logic [31:0] tgt;
        id_valid     = 1'b1;
        id_is_branch = (kind == K_BR);
        id_is_jal    = (kind == K_JAL);
        id_is_jalr   = (kind == K_JALR);
        id_funct3    = f3;
        id_pc        = pc;
        id_imm       = imm;
        rs1_data     = r1;
        rs2_data     = r2;
        rs1_ready    = 1'b1;
        rs2_ready    = 1'b1;
        // a redirect pulse in flight makes this ID slot wrong-path
        for (int g = 0; g < 4 && exp_rv; g++) begin
            exp_stall = 1'b0;
            tick();
        end
        for (int i = 0; i < nrdy; i++) begin
            rs1_data = 32'h8000_0000;
            rs2_data = 32'h7FFF_FFFF;
            if (kind == K_JALR) rs1_ready = 1'b0;
            else rs2_ready = 1'b0;
            exp_stall = 1'b1;
            tick();
        end
        rs1_data  = r1;
        rs2_data  = r2;
        rs1_ready = (kind != K_JAL);
        rs2_ready = (kind == K_BR);
        exp_stall = 1'b1;
        tick();
        // resolve cycle: ID released, operands on the bus change afterwards
        rs1_data  = ~r1;
        rs2_data  = r2 + 32'h1234_5678;
        rs1_ready = 1'b1;
        rs2_ready = 1'b1;
        id_valid  = 1'b0;
        flush_in  = fl;
        exp_stall = 1'b0;
        exp_ctrl  = (kind == K_BR) ? exp_code(f3) : 3'b000;
        in_cmp    = 1'b1;
        exp_a     = r1;
        exp_b     = r2;
        tk  = (kind != K_BR) || br_taken(f3, r1, r2);
        tgt = (kind == K_JALR) ? ((r1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        if (!fl) begin
            nxt_br = 1'b1;
            nxt_tk = tk;
            if (tk && !tgt[1]) begin
                nxt_rv = 1'b1;
                nxt_pc = tgt;
            end
            if (tk && tgt[1]) nxt_exc = 1'b1;
        end
        tick();
        flush_in     = 1'b0;
        id_is_branch = 1'b0;
        id_is_jal    = 1'b0;
        id_is_jalr   = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_is_branch = 1'b0; id_is_jal = 1'b0; id_is_jalr = 1'b0;
        id_funct3 = 3'b000; id_pc = 32'h0; id_imm = 32'h0;
        rs1_data = 32'h0; rs2_data = 32'h0; rs1_ready = 1'b1; rs2_ready = 1'b1;
        flush_in = 1'b0;
        #3;
        chk("rst_stall", {31'd0, stall_id}, 32'h0);
        chk("rst_redirect", {31'd0, redirect_valid}, 32'h0);
        chk("rst_ctrl", {29'd0, cmp_ctrl}, 32'h0);
        chk("rst_br_cnt", br_cnt, 32'h0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // BEQ taken, ready operands
        do_op(K_BR, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 0, 1'b0);
        chk("beq_redirect", {31'd0, redirect_valid}, 32'h1);
        chk("beq_pc", redirect_pc, 32'h120);
        chk("beq_br_cnt", br_cnt, 32'd1);
        chk("beq_taken_cnt", taken_cnt, 32'd1);
        idle(2);

        // BLT signed taken, then BLTU with the same operands not taken
        do_op(K_BR, 3'b100, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        chk("blt_pc", redirect_pc, 32'h340);
        do_op(K_BR, 3'b110, 32'h344, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        chk("bltu_no_redirect", {31'd0, redirect_valid}, 32'h0);
        chk("bltu_taken_cnt", taken_cnt, 32'd2);
        idle(1);

        // BGE with rs2 not ready for three cycles; garbage during wait would flip it
        do_op(K_BR, 3'b101, 32'h400, 32'hFFFF_FFF8, 32'd7, 32'd3, 3, 1'b0);
        chk("bge_pc", redirect_pc, 32'h3F8);
        idle(1);

        // jalr aligned, jal misaligned
        do_op(K_JALR, 3'b000, 32'h500, 32'h3, 32'h1001, 32'h0, 1, 1'b0);
        chk("jalr_pc", redirect_pc, 32'h1004);
        do_op(K_JAL, 3'b000, 32'h200, 32'h6, 32'h0, 32'h0, 0, 1'b0);
        chk("jal_exc", {31'd0, exc_misalign}, 32'h1);
        chk("jal_no_redirect", {31'd0, redirect_valid}, 32'h0);
        chk("jal_taken_cnt", taken_cnt, 32'd5);
        idle(1);

        // BNE taken but flushed in CMP; next op accepted straight from IDLE
        do_op(K_BR, 3'b001, 32'h600, 32'h10, 32'd1, 32'd2, 0, 1'b1);
        chk("flush_no_redirect", {31'd0, redirect_valid}, 32'h0);
        chk("flush_br_cnt", br_cnt, 32'd6);
        do_op(K_BR, 3'b000, 32'h700, 32'h10, 32'd1, 32'd2, 0, 1'b0);
        idle(1);

        // asynchronous reset while waiting on rs2
        id_valid = 1'b1; id_is_branch = 1'b1; id_funct3 = 3'b000;
        rs1_ready = 1'b1; rs2_ready = 1'b0;
        exp_stall = 1'b1;
        tick();
        exp_stall = 1'b1;
        #1;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("arst_stall", {31'd0, stall_id}, 32'h0);
        chk("arst_redirect", {31'd0, redirect_valid}, 32'h0);
        chk("arst_exc", {31'd0, exc_misalign}, 32'h0);
        chk("arst_ctrl", {29'd0, cmp_ctrl}, 32'h0);
        chk("arst_rpc", redirect_pc, 32'h0);
        chk("arst_br_cnt", br_cnt, 32'h0);
        chk("arst_taken_cnt", taken_cnt, 32'h0);
        chk("arst_cmp_a", cmp_a, 32'h0);
        chk("arst_cmp_b", cmp_b, 32'h0);
        id_valid = 1'b0; id_is_branch = 1'b0; rs2_ready = 1'b1;
        exp_stall = 1'b0; exp_rv = 1'b0; exp_exc = 1'b0; exp_ctrl = 3'b000; in_cmp = 1'b0;
        exp_rpc = 32'h0; exp_br = 32'h0; exp_tk = 32'h0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        idle(1);

        // back-to-back not-taken branches, then funct3=010 wraps the 4-bit counter
        for (int k = 0; k < 15; k++)
            do_op(K_BR, 3'b001, 32'h800 + 32'(k * 4), 32'h40, 32'd9, 32'd9, 0, 1'b0);
        chk("br4_at_15", {28'd0, br_cnt4}, 32'hF);
        do_op(K_BR, 3'b010, 32'h900, 32'h40, 32'd3, 32'd3, 0, 1'b0);
        chk("br4_wrap", {28'd0, br_cnt4}, 32'h0);
        chk("br_cnt_16", br_cnt, 32'd16);
        chk("f3_010_not_taken", taken_cnt, 32'd0);
        idle(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences the shared 32-bit comparator in the ID stage of the pipelined RV32I core.
- Decodes branch, jal and jalr control; drives the comparator's a/b/ctrl inputs from registered operands; stalls ID while operands are not ready.
- Produces a one-cycle redirect and flush pulse for taken control transfers. Static predict-not-taken.
- Keeps branch and taken statistics counters.

Parameters:
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_is_branch  in  1  instruction is a conditional branch.
- id_is_jal  in  1  instruction is jal.
- id_is_jalr  in  1  instruction is jalr.
- id_funct3  in  3  branch funct3.
- id_pc  in  32  PC of the ID instruction.
- id_imm  in  32  sign-extended immediate.
- rs1_data, rs2_data  in  32 each  forwarded operands.
- rs1_ready, rs2_ready  in  1 each  operand valid this cycle (low on load-use hazard).
- flush_in  in  1  trap/exception flush from later stages.
- cmp_a, cmp_b  out  32 each  comparator operands.
- cmp_ctrl  out  3  comparator op: EQ=001, NE=010, LT=011, LTU=100, GE=101, GEU=110, none=000.
- cmp_c  in  1  comparator result.
- stall_id  out  1  hold IF/ID.
- redirect_valid  out  1  one-cycle redirect pulse.
- redirect_pc  out  32  redirect target.
- flush_fetch  out  1  kill IF and ID contents; equals redirect_valid.
- exc_misalign  out  1  one-cycle misaligned-target exception pulse.
- br_cnt  out  CNT_W  resolved control transfers.
- taken_cnt  out  CNT_W  taken control transfers.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all operand registers, redirect_pc and counters are 0; redirect_valid, exc_misalign, stall_id are 0; cmp_ctrl=000.
- ctl = id_valid & (id_is_branch | id_is_jal | id_is_jalr) & ~redirect_valid & ~flush_in.
- need_ok: branch needs rs1_ready & rs2_ready; jalr needs rs1_ready; jal needs none.
- FSM states IDLE, WAIT, CMP.
  - IDLE: if ctl & ~need_ok, go to WAIT with stall_id=1. If ctl & need_ok, capture op type, funct3, pc, imm, rs1_data, rs2_data, go to CMP with stall_id=1.
  - WAIT: stall_id=1. Once need_ok, capture operands and go to CMP.
  - CMP: stall_id=0, so the instruction leaves ID.
    - cmp_a and cmp_b come from the captured registers; cmp_ctrl is decoded from captured funct3 only when the op is a branch, otherwise 000.
    - Funct3 map: 000→001, 001→010, 100→011, 101→101, 110→100, 111→110. Funct3 010/011 → 000, so the branch is never taken.
    - taken = jal | jalr | (branch & cmp_c).
    - Target: pc+imm for branch and jal; (rs1+imm) with bit0 cleared for jalr. Arithmetic is 32-bit with wrap.
    - Registered outputs, valid the next cycle for exactly one cycle:
      - taken & target[1]=0: redirect_valid=1, redirect_pc=target.
      - taken & target[1]=1: exc_misalign=1, no redirect.
    - br_cnt+1. If taken (misaligned included), taken_cnt+1. Both counters wrap modulo 2^CNT_W.
    - Next state is IDLE.
- In all other states cmp_ctrl=000.
- Latency: with ready operands, branch enters ID at cycle t, stall at t, CMP at t+1, redirect at t+2. Taken penalty is 3 cycles.
- While redirect_valid=1, id_valid is ignored; the ID instruction is wrong-path and is being flushed.
- flush_in in any state: next state IDLE, no redirect/exc pulse generated from the current op, no counter update, stall_id=0 that cycle.
- A redirect_valid already registered still pulses; the PC mux gives flush_in priority.
- Back-to-back branches: a not-taken branch in CMP lets the next ID branch be accepted in the following IDLE cycle, with no idle gap beyond the IDLE cycle.
- Operands are sampled only at capture. Later changes on rs*_data have no effect.

Test Plan:
- BEQ pc=0x100, imm=0x20, rs1=rs2=5, ready → stall_id high 1 cycle; cmp_ctrl=001 in CMP; redirect_valid pulse with redirect_pc=0x120 two cycles after entry; br_cnt=1, taken_cnt=1.
- BLT rs1=0xFFFFFFFF, rs2=1 → cmp_ctrl=011, taken. Then BLTU with the same operands → cmp_ctrl=100, not taken: no redirect, taken_cnt unchanged.
- BGE with rs2_ready low 3 cycles → stall_id high 4 cycles (WAIT ×3 plus capture); operand changes during WAIT are used only from the ready cycle.
- jalr rs1=0x1001, imm=0x3 → target 0x1004, redirect. jal pc=0x200, imm=0x6 → target 0x206, exc_misalign pulse, no redirect, taken_cnt+1.
- flush_in asserted in CMP for a taken BNE → no redirect, counters unchanged, state IDLE. Async rst_n low mid-WAIT → all outputs 0 immediately.
- Funct3=010 branch → cmp_ctrl=000, not taken, br_cnt+1. Preload br_cnt to 2^CNT_W−1 (CNT_W=4 build) → wraps to 0.
